// File: rtl/id_ex_pipe_if.sv
// ID/EX bus: decode-side inputs, EX-side registered outputs and stall/flush controls.
interface id_ex_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RA_W   = 3,
    parameter int unsigned CNT_W  = 8
);
    localparam int unsigned CTRL_W = 14;

    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc1;
    logic [RA_W-1:0]   id_rs;
    logic [RA_W-1:0]   id_rt;
    logic [RA_W-1:0]   id_rd;
    logic              flush;
    logic              ex_stall;
    logic              stall_id;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc1;
    logic [RA_W-1:0]   ex_rs;
    logic [RA_W-1:0]   ex_rt;
    logic [RA_W-1:0]   ex_dst;
    logic [CNT_W-1:0]  bubble_cnt;

    // Decode side: drives the ID slot and the pipeline controls.
    modport master (
        output id_valid, id_ctrl, id_rdata1, id_rdata2, id_imm, id_pc1,
               id_rs, id_rt, id_rd, flush, ex_stall,
        input  stall_id, ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm,
               ex_pc1, ex_rs, ex_rt, ex_dst, bubble_cnt
    );

    // Pipeline register side.
    modport slave (
        input  id_valid, id_ctrl, id_rdata1, id_rdata2, id_imm, id_pc1,
               id_rs, id_rt, id_rd, flush, ex_stall,
        output stall_id, ex_valid, ex_ctrl, ex_rdata1, ex_rdata2, ex_imm,
               ex_pc1, ex_rs, ex_rt, ex_dst, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with destination resolution, load-use bubble
// insertion, flush/hold handling and a saturating bubble counter.
module id_ex_pipe #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RA_W     = 3,
    parameter int unsigned LINK_REG = 7,
    parameter int unsigned CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_pipe_if.slave  bus
);
    localparam int unsigned CTRL_W     = 14;
    localparam int unsigned B_ALUSRC   = 8;
    localparam int unsigned B_BRANCH   = 7;
    localparam int unsigned B_JAL      = 6;
    localparam int unsigned B_MEMWRITE = 3;
    localparam int unsigned B_MEMREAD  = 2;
    localparam int unsigned B_REGDST   = 0;

    logic              r_ex_valid;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [DATA_W-1:0] r_ex_rdata1;
    logic [DATA_W-1:0] r_ex_rdata2;
    logic [DATA_W-1:0] r_ex_imm;
    logic [DATA_W-1:0] r_ex_pc1;
    logic [RA_W-1:0]   r_ex_rs;
    logic [RA_W-1:0]   r_ex_rt;
    logic [RA_W-1:0]   r_ex_dst;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic [RA_W-1:0]   w_dst;
    logic              w_uses_rt;
    logic              w_hz;
    logic              w_cnt_sat;

    // Destination, rt usage and load-use hazard against the load currently in EX.
    always_comb begin
        w_dst = bus.id_ctrl[B_REGDST] ? bus.id_rd : bus.id_rt;
        if (bus.id_ctrl[B_JAL]) begin
            w_dst = RA_W'(LINK_REG);
        end
        w_uses_rt = ~bus.id_ctrl[B_ALUSRC] | bus.id_ctrl[B_MEMWRITE] | bus.id_ctrl[B_BRANCH];
        w_hz = r_ex_valid & r_ex_ctrl[B_MEMREAD] & (r_ex_dst != '0) & bus.id_valid
             & ((bus.id_rs == r_ex_dst) | (w_uses_rt & (bus.id_rt == r_ex_dst)));
        w_cnt_sat = (r_bubble_cnt == {CNT_W{1'b1}});
    end

    // A flush wins the hazard, so no bubble is counted and ID is not held for it.
    assign bus.stall_id = rst_n & (bus.ex_stall | (w_hz & ~bus.flush));

    // Pipeline register update: reset > flush > hold > bubble > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_rdata1  <= '0;
            r_ex_rdata2  <= '0;
            r_ex_imm     <= '0;
            r_ex_pc1     <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_dst     <= '0;
            r_bubble_cnt <= '0;
        end else if (bus.flush || (!bus.ex_stall && w_hz)) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= '0;
            r_ex_rdata1 <= '0;
            r_ex_rdata2 <= '0;
            r_ex_imm    <= '0;
            r_ex_pc1    <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_dst    <= '0;
            if (!bus.flush && !w_cnt_sat) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (!bus.ex_stall) begin
            r_ex_valid  <= bus.id_valid;
            r_ex_ctrl   <= bus.id_valid ? bus.id_ctrl : '0;
            r_ex_rdata1 <= bus.id_rdata1;
            r_ex_rdata2 <= bus.id_rdata2;
            r_ex_imm    <= bus.id_imm;
            r_ex_pc1    <= bus.id_pc1;
            r_ex_rs     <= bus.id_rs;
            r_ex_rt     <= bus.id_rt;
            r_ex_dst    <= w_dst;
        end
    end

    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_ctrl    = r_ex_ctrl;
    assign bus.ex_rdata1  = r_ex_rdata1;
    assign bus.ex_rdata2  = r_ex_rdata2;
    assign bus.ex_imm     = r_ex_imm;
    assign bus.ex_pc1     = r_ex_pc1;
    assign bus.ex_rs      = r_ex_rs;
    assign bus.ex_rt      = r_ex_rt;
    assign bus.ex_dst     = r_ex_dst;
    assign bus.bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_id_ex_pipe;
    localparam logic [13:0] C_ADD  = {4'h1, 10'b1000000001};
    localparam logic [13:0] C_LW   = {4'h0, 10'b1100000110};
    localparam logic [13:0] C_ADDI = {4'h1, 10'b1100000000};
    localparam logic [13:0] C_SW   = {4'h0, 10'b0100001000};
    localparam logic [13:0] C_JAL  = {4'h0, 10'b1001000000};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_pipe_if #(.DATA_W(16), .RA_W(3), .CNT_W(8)) bus ();

    id_ex_pipe #(.DATA_W(16), .RA_W(3), .LINK_REG(7), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what EX currently holds and how many bubbles were inserted.
    logic        m_valid;
    logic [13:0] m_ctrl;
    logic [15:0] m_r1, m_r2, m_imm, m_pc1;
    logic [2:0]  m_rs, m_rt, m_dst;
    int          m_cnt;

    function automatic logic m_hazard();
        logic uses_rt;
        uses_rt = !bus.id_ctrl[8] || bus.id_ctrl[3] || bus.id_ctrl[7];
        return m_valid && m_ctrl[2] && (m_dst != 3'd0) && bus.id_valid &&
               ((bus.id_rs == m_dst) || (uses_rt && (bus.id_rt == m_dst)));
    endfunction

    function automatic logic m_stall();
        return rst_n && (bus.ex_stall || (m_hazard() && !bus.flush));
    endfunction

    function automatic logic [87:0] exp_vec();
        return {m_valid, m_ctrl, m_r1, m_r2, m_imm, m_pc1, m_rs, m_rt, m_dst};
    endfunction

    function automatic logic [87:0] obs_vec();
        return {bus.ex_valid, bus.ex_ctrl, bus.ex_rdata1, bus.ex_rdata2, bus.ex_imm,
                bus.ex_pc1, bus.ex_rs, bus.ex_rt, bus.ex_dst};
    endfunction

    task automatic model_bubble();
        m_valid = 1'b0; m_ctrl = '0; m_r1 = '0; m_r2 = '0; m_imm = '0; m_pc1 = '0;
        m_rs = '0; m_rt = '0; m_dst = '0;
    endtask

    // One clock edge: decide the model's next contents from pre-edge inputs, then advance.
    task automatic cycle();
        logic hz;
        logic ld;
        logic [2:0] d;
        hz = m_hazard();
        ld = 1'b0;
        if (!rst_n) begin
            model_bubble();
            m_cnt = 0;
        end else if (bus.flush) begin
            model_bubble();
        end else if (bus.ex_stall) begin
            ld = 1'b0;
        end else if (hz) begin
            model_bubble();
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else begin
            ld = 1'b1;
        end
        if (ld) begin
            if (bus.id_ctrl[6])      d = 3'd7;
            else if (bus.id_ctrl[0]) d = bus.id_rd;
            else                     d = bus.id_rt;
            m_valid = bus.id_valid;
            m_ctrl  = bus.id_valid ? bus.id_ctrl : 14'd0;
            m_r1 = bus.id_rdata1; m_r2 = bus.id_rdata2; m_imm = bus.id_imm; m_pc1 = bus.id_pc1;
            m_rs = bus.id_rs; m_rt = bus.id_rt; m_dst = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [13:0] c, input logic [2:0] rs,
                             input logic [2:0] rt, input logic [2:0] rd, input logic [15:0] r1);
        bus.id_valid = v; bus.id_ctrl = c; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rdata1 = r1; bus.id_rdata2 = 16'($urandom);
        bus.id_imm = 16'($urandom); bus.id_pc1 = 16'($urandom);
    endtask

    task automatic test_reset();
        set_instr(1'b1, C_ADD, 3'd1, 3'd2, 3'd3, 16'hBEEF);
        bus.flush = 1'b0; bus.ex_stall = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL reset_stall_id: got %b want 0", bus.stall_id);
        end
        cycle(); cycle();
        checks++;
        if (obs_vec() !== 88'd0 || bus.bubble_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_outputs: got %h cnt %0d want 0 cnt 0", obs_vec(), bus.bubble_cnt);
        end
        rst_n = 1'b1; bus.ex_stall = 1'b0;
        cycle();
        checks++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rdata1, bus.ex_dst} !== {1'b1, C_ADD, 16'hBEEF, 3'd3}) begin
            errors++; $display("FAIL reset_release: got v%b c%h d%h dst%0d", bus.ex_valid, bus.ex_ctrl, bus.ex_rdata1, bus.ex_dst);
        end
    endtask

    task automatic test_basic();
        set_instr(1'b1, C_ADD, 3'd1, 3'd2, 3'd3, 16'h0005);
        cycle();
        checks++;
        if ({bus.ex_valid, bus.ex_ctrl[9], bus.ex_rdata1, bus.ex_dst} !== {1'b1, 1'b1, 16'h0005, 3'd3}) begin
            errors++; $display("FAIL add_basic: got v%b wen%b d%h dst%0d want v1 wen1 d0005 dst3",
                               bus.ex_valid, bus.ex_ctrl[9], bus.ex_rdata1, bus.ex_dst);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL add_model: got %h want %h", obs_vec(), exp_vec());
        end
        set_instr(1'b1, C_JAL, 3'd0, 3'd2, 3'd5, 16'h0010);
        cycle();
        checks++;
        if (bus.ex_dst !== 3'd7) begin
            errors++; $display("FAIL jal_dst: got %0d want 7", bus.ex_dst);
        end
    endtask

    task automatic test_load_use();
        int c0;
        set_instr(1'b1, C_LW, 3'd1, 3'd4, 3'd0, 16'h0001);
        cycle();
        set_instr(1'b1, C_ADD, 3'd4, 3'd2, 3'd3, 16'h0022);
        c0 = m_cnt;
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) begin
            errors++; $display("FAIL lu_stall: got %b want 1", bus.stall_id);
        end
        cycle();
        checks++;
        if ({bus.ex_valid, bus.ex_ctrl, 8'(bus.bubble_cnt)} !== {1'b0, 14'd0, 8'(c0 + 1)}) begin
            errors++; $display("FAIL lu_bubble: got v%b c%h cnt%0d want v0 c0 cnt%0d",
                               bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, c0 + 1);
        end
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL lu_clear: got %b want 0", bus.stall_id);
        end
        cycle();
        checks++;
        if ({bus.ex_valid, bus.ex_ctrl, bus.ex_rdata1, bus.ex_dst} !== {1'b1, C_ADD, 16'h0022, 3'd3}) begin
            errors++; $display("FAIL lu_resume: got v%b c%h d%h dst%0d", bus.ex_valid, bus.ex_ctrl, bus.ex_rdata1, bus.ex_dst);
        end
        set_instr(1'b1, C_LW, 3'd1, 3'd0, 3'd0, 16'h0001);
        cycle();
        set_instr(1'b1, C_ADD, 3'd0, 3'd0, 3'd3, 16'h0002);
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL lu_r0: got %b want 0", bus.stall_id);
        end
        cycle();
    endtask

    task automatic test_uses_rt();
        set_instr(1'b1, C_LW, 3'd1, 3'd4, 3'd0, 16'h0001);
        cycle();
        set_instr(1'b1, C_ADDI, 3'd2, 3'd4, 3'd0, 16'h0002);
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL addi_no_stall: got %b want 0", bus.stall_id);
        end
        cycle();
        set_instr(1'b1, C_LW, 3'd1, 3'd4, 3'd0, 16'h0001);
        cycle();
        set_instr(1'b1, C_SW, 3'd2, 3'd4, 3'd0, 16'h0003);
        #1;
        checks++;
        if (bus.stall_id !== 1'b1) begin
            errors++; $display("FAIL sw_stall: got %b want 1", bus.stall_id);
        end
        cycle();
        cycle();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL sw_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_flush_hz();
        int c0;
        set_instr(1'b1, C_LW, 3'd1, 3'd4, 3'd0, 16'h0001);
        cycle();
        set_instr(1'b1, C_ADD, 3'd4, 3'd2, 3'd3, 16'h0005);
        bus.flush = 1'b1;
        c0 = m_cnt;
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL flush_hz_stall: got %b want 0", bus.stall_id);
        end
        cycle();
        bus.flush = 1'b0;
        checks++;
        if ({bus.ex_valid, bus.ex_ctrl, 8'(bus.bubble_cnt)} !== {1'b0, 14'd0, 8'(c0)}) begin
            errors++; $display("FAIL flush_hz_out: got v%b c%h cnt%0d want v0 c0 cnt%0d",
                               bus.ex_valid, bus.ex_ctrl, bus.bubble_cnt, c0);
        end
    endtask

    task automatic test_ex_stall();
        set_instr(1'b1, C_ADD, 3'd5, 3'd6, 3'd1, 16'h1234);
        cycle();
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 14'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
            #1;
            checks++;
            if (bus.stall_id !== 1'b1) begin
                errors++; $display("FAIL hold_stall[%0d]: got %b want 1", i, bus.stall_id);
            end
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.ex_rdata1 !== 16'h1234) begin
                errors++; $display("FAIL hold_frozen[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        bus.ex_stall = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        set_instr(1'b1, C_LW, 3'd1, 3'd4, 3'd0, 16'h0001);
        cycle();
        set_instr(1'b1, C_ADD, 3'd4, 3'd2, 3'd3, 16'h0005);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall_id !== 1'b0) begin
            errors++; $display("FAIL rst_mid_stall: got %b want 0", bus.stall_id);
        end
        cycle();
        checks++;
        if (obs_vec() !== 88'd0 || bus.bubble_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_mid_out: got %h cnt %0d want 0", obs_vec(), bus.bubble_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [13:0] c;
            c = 14'($urandom);
            c[2] = ($urandom_range(0, 9) < 4);
            set_instr($urandom_range(0, 99) < 85, c, 3'($urandom_range(0, 4)),
                      3'($urandom_range(0, 4)), 3'($urandom), 16'($urandom));
            bus.flush    = ($urandom_range(0, 99) < 10);
            bus.ex_stall = ($urandom_range(0, 99) < 10);
            #1;
            checks++;
            if (bus.stall_id !== m_stall()) begin
                errors++; $display("FAIL rand_stall[%0d]: got %b want %b", i, bus.stall_id, m_stall());
            end
            cycle();
            checks++;
            if (obs_vec() !== exp_vec() || bus.bubble_cnt !== 8'(m_cnt)) begin
                errors++; $display("FAIL rand_state[%0d]: got %h cnt%0d want %h cnt%0d",
                                   i, obs_vec(), bus.bubble_cnt, exp_vec(), m_cnt);
            end
            checks++;
            if (!bus.ex_valid && (bus.ex_ctrl[9] || bus.ex_ctrl[3])) begin
                errors++; $display("FAIL rand_bubble_writes[%0d]: got ctrl %h want wen=0 memWrite=0", i, bus.ex_ctrl);
            end
        end
        bus.flush = 1'b0; bus.ex_stall = 1'b0;
    endtask

    task automatic test_saturation();
        int n;
        n = 0;
        set_instr(1'b1, C_LW, 3'd4, 3'd4, 3'd0, 16'h0001);
        while (m_cnt < 254 && n < 2000) begin
            cycle();
            n++;
        end
        checks++;
        if (bus.bubble_cnt !== 8'd254) begin
            errors++; $display("FAIL sat_preload: got %0d want 254", bus.bubble_cnt);
        end
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (bus.bubble_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_reach: got %0d want 255", bus.bubble_cnt);
        end
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (bus.bubble_cnt !== 8'd255) begin
            errors++; $display("FAIL sat_hold: got %0d want 255", bus.bubble_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_cnt  = 0;
        model_bubble();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.ex_stall = 1'b0;
        set_instr(1'b0, 14'd0, 3'd0, 3'd0, 3'd0, 16'd0);
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_load_use();
        test_uses_rt();
        test_flush_hz();
        test_ex_stall();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register fed directly by the instruction-decode control unit and the register file; feeds the EX stage and the forwarding unit.
- Latches decoded control, operands, immediate, register specifiers and PC+1.
- Resolves the write destination (rd, rt or link register).
- Detects load-use hazards and inserts a single bubble. Honours branch flush and downstream hold.
- Keeps a saturating count of inserted load-use bubbles.

Parameters:
- DATA_W, 16, width of operands, immediate and PC.
- RA_W, 3, register-specifier width; register 0 is hardwired zero.
- LINK_REG, 7, destination register written by JAL.
- CNT_W, 8, bubble-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  the ID slot holds a real instruction.
- id_ctrl  in  14  decoded control: [13:10] aluop, [9] wen, [8] alusrc, [7] branch, [6] jal, [5] jr, [4] jump, [3] memWrite, [2] memRead, [1] memtoReg, [0] regDst.
- id_rdata1  in  DATA_W  rs operand.
- id_rdata2  in  DATA_W  rt operand.
- id_imm  in  DATA_W  sign-extended immediate.
- id_pc1  in  DATA_W  PC+1 of the ID instruction.
- id_rs, id_rt, id_rd  in  RA_W each  register specifiers.
- flush  in  1  kill the instruction entering EX (branch/jump taken).
- ex_stall  in  1  downstream hold; freeze this register.
- stall_id  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  registered valid.
- ex_ctrl  out  14  registered control, same bit map as id_ctrl.
- ex_rdata1, ex_rdata2, ex_imm, ex_pc1  out  DATA_W each  registered data.
- ex_rs, ex_rt  out  RA_W each  registered sources, for the forwarding unit.
- ex_dst  out  RA_W  resolved destination.
- bubble_cnt  out  CNT_W  inserted load-use bubbles, saturating.

Behaviour:
- Reset: rst_n=0 sampled at an edge clears every registered output and bubble_cnt to 0. stall_id is combinational and forced to 0 while rst_n=0. Reset mid-stall drops the held instruction.
- Destination: dst = jal ? LINK_REG : (regDst ? id_rd : id_rt).
- Latency: one cycle from ID inputs to ex_* outputs.
- Uses-rt term: uses_rt = ~alusrc | memWrite | branch, all taken from id_ctrl.
- Load-use hazard, combinational: hz = ex_valid & ex_ctrl[2] & (ex_dst != 0) & id_valid & ((id_rs == ex_dst) | (uses_rt & id_rt == ex_dst)).
- stall_id = ex_stall | (hz & ~flush).
- Per-edge priority, highest first:
  1. Reset.
  2. flush: load a bubble — ex_valid=0, ex_ctrl=0, data and specifiers 0. flush overrides ex_stall.
  3. ex_stall: hold every register; bubble_cnt unchanged.
  4. hz: load a bubble and increment bubble_cnt.
  5. Otherwise: load ID inputs. ex_valid=id_valid. ex_ctrl=id_valid ? id_ctrl : 0.
- Bubble guarantee: a bubble never writes the register file or memory (wen=0, memWrite=0).
- Hazard clearing: a single bubble clears the hazard, because the load has moved past EX. The next edge loads the waiting instruction, whose operand is then forwarded from MEM/WB.
- Counter: bubble_cnt saturates at 2^CNT_W-1 and never wraps.
- Simultaneous flush and hz: bubble inserted, stall_id=0, bubble_cnt unchanged.
- Simultaneous ex_stall and hz: hold; the hazard is re-evaluated after release.

Test Plan:
- Reset: drive nonzero inputs, hold rst_n=0 for 2 edges -> all ex_* = 0, bubble_cnt = 0, stall_id = 0. Release -> the first instruction appears after 1 edge.
- ADD (wen=1, regDst=1), rs=1 rt=2 rd=3, rdata1=0x0005 -> next cycle ex_dst=3, ex_ctrl[9]=1, ex_rdata1=0x0005, ex_valid=1. JAL -> ex_dst=7.
- LW to rt=4 (memRead=1, regDst=0), then ADD with rs=4:
  - stall_id=1 during the ADD's ID cycle.
  - Next cycle: ex_valid=0, ex_ctrl=0, bubble_cnt=1.
  - Following cycle: ADD in EX.
  - Repeat with LW to rt=0 -> no stall.
- LW rt=4 followed by ADDI with rt=4 as its destination (alusrc=1, rs=2) -> no stall. SW with rt=4 -> stall.
- Load-use and flush together -> ex_valid=0, stall_id=0, bubble_cnt unchanged.
- ex_stall=1 for 3 cycles with changing ID inputs -> ex_* frozen, stall_id=1.
- Preload 254 load-use bubbles, then 3 more -> bubble_cnt reads 255 and stays there.
